genbuf_fifo: RTL and testbench
==============================

# genbuf_fifo

Data-path FIFO for the generalized buffer. It is driven by the GenBuf controller's ENQ, DEQ and SLC0 outputs and returns the FULL and EMPTY status that the controller samples. It stores sender words on enqueue and, on dequeue, delivers the head word to the receiver selected by SLC0, with a one-cycle valid strobe.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- AW, $clog2(DEPTH), pointer width (derived, not overridable)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- ENQ  in  1  write DI into the tail this cycle
- DEQ  in  1  pop the head this cycle
- SLC0  in  1  receiver select for the current DEQ: 0 → receiver 0, 1 → receiver 1
- DI  in  WIDTH  sender data, sampled when ENQ=1
- FULL  out  1  registered; 1 when count == DEPTH
- EMPTY  out  1  registered; 1 when count == 0
- LEVEL  out  AW+1  registered occupancy count
- DO0  out  WIDTH  registered data for receiver 0
- DO1  out  WIDTH  registered data for receiver 1
- VALID0  out  1  one-cycle strobe: DO0 updated
- VALID1  out  1  one-cycle strobe: DO1 updated
- OVF_ERR  out  1  sticky overflow flag
- UDF_ERR  out  1  sticky underflow flag

## Operation
- Storage: DEPTH×WIDTH register array, write pointer wp, read pointer rp, occupancy count cnt (AW+1 bits). Pointers wrap modulo DEPTH by natural AW-bit overflow.
- Effective write: we = ENQ & (!FULL | DEQ).
- Effective read: re = DEQ & !EMPTY.
- On we: mem[wp] <= DI; wp <= wp+1.
- On re: rp <= rp+1. The word mem[rp] goes to DO0 when SLC0=0, otherwise to DO1. VALID0 or VALID1 is 1 in the next cycle only.
- cnt update: we&!re → +1; re&!we → −1; otherwise unchanged.
- FULL, EMPTY and LEVEL are computed from the next value of cnt, so they are exact in the cycle after the edge.
- Full with ENQ&DEQ: both take effect, count stays at DEPTH, FULL stays 1, no overflow.
- Empty with ENQ&DEQ: the write takes effect, the read does not (no bypass), UDF_ERR is set, and EMPTY drops next cycle.
- ENQ while FULL with DEQ=0: the write is dropped, memory and wp are unchanged, OVF_ERR is set.
- DEQ while EMPTY: no pop, no VALID strobe, UDF_ERR is set.
- OVF_ERR and UDF_ERR stay set until reset.
- DO0 and DO1 hold their last value when not updated.

## Timing
- Reset values: wp=rp=cnt=0, FULL=0, EMPTY=1, LEVEL=0, DO0=DO1=0, VALID0=VALID1=0, OVF_ERR=UDF_ERR=0. Memory contents are not reset.
- Reset has priority over ENQ and DEQ in the same cycle. Reset mid-operation discards all entries; in-flight VALID strobes are cleared the next cycle.
- Enqueue latency: a word written at edge t can be dequeued at edge t+1 at the earliest (EMPTY=0 after t).
- Dequeue latency: DEQ sampled at edge t → DOx and VALIDx valid in the cycle after t.
- Status latency: FULL and EMPTY reflect all ENQ/DEQ up to edge t immediately after t. The controller sees them one cycle later through its own _p registers; this is intended.

## Structure
- Package genbuf_pkg holds:
  - the receiver-index constants RCV0=0, RCV1=1;
  - the error-bit positions;
  - the parameter legality check function is_pow2.
- Sub-module genbuf_fifo_mem holds the register array: one write port, one asynchronous read port indexed by rp, no reset.
- Pointer, count, flag and output-register logic stays in genbuf_fifo.
- An elaboration-time assertion rejects DEPTH that is not a power of two or is <2.

## Test plan
- Reset, then fill: with DEPTH=4, enqueue 0x11, 0x22, 0x33, 0x44 on consecutive cycles → LEVEL steps 1,2,3,4; FULL=1 after the 4th edge; EMPTY=0 after the 1st edge.
- Drain with alternating SLC0=0,1,0,1 → DO0=0x11 with VALID0, then DO1=0x22 with VALID1, DO0=0x33, DO1=0x44, one cycle after each DEQ; EMPTY=1 after the 4th.
- Full with simultaneous ENQ(0x55)&DEQ → head 0x11 delivered, LEVEL stays 4, OVF_ERR=0; after draining, 0x55 comes out last.
- Overflow and underflow:
  - ENQ 0x66 while FULL with DEQ=0 → OVF_ERR=1, contents unchanged;
  - DEQ while EMPTY → UDF_ERR=1, no VALID strobe;
  - both flags stay set until reset.
- Wrap-around: push and pop 10 words with random interleaving, never exceeding 3 in flight → output order matches input order and pointers wrap cleanly.
- Reset mid-operation: reset asserted with LEVEL=2 and ENQ=1 → next cycle EMPTY=1, LEVEL=0, VALIDx=0, flags cleared.

Source files
------------

// File: rtl/genbuf_pkg.sv
// rtl/genbuf_pkg.sv - shared constants and helpers for the GenBuf data-path FIFO
//
// Purpose : receiver-select encodings, sticky error-bit positions and the
//           DEPTH legality helper used at elaboration time.
// Ports   : none (package).

package genbuf_pkg;

  // Receiver selected by SLC0 during a dequeue.
  localparam logic RCV0 = 1'b0;
  localparam logic RCV1 = 1'b1;

  // Bit positions inside the sticky error register.
  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_W   = 2;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/genbuf_fifo_if.sv
// rtl/genbuf_fifo_if.sv - controller-to-FIFO handshake and status bundle
//
// Purpose : groups the GenBuf controller commands (ENQ/DEQ/SLC0/DI) and the
//           FIFO status and receiver outputs into one port.
// Ports   : master - controller side: drives ENQ, DEQ, SLC0, DI; observes
//                    FULL, EMPTY, LEVEL, DO0/DO1, VALID0/VALID1, OVF/UDF_ERR.
//           slave  - FIFO side: the mirror image of master.

interface genbuf_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             ENQ;
  logic             DEQ;
  logic             SLC0;
  logic [WIDTH-1:0] DI;
  logic             FULL;
  logic             EMPTY;
  logic [AW:0]      LEVEL;
  logic [WIDTH-1:0] DO0;
  logic [WIDTH-1:0] DO1;
  logic             VALID0;
  logic             VALID1;
  logic             OVF_ERR;
  logic             UDF_ERR;

  modport master (
    output ENQ, DEQ, SLC0, DI,
    input  FULL, EMPTY, LEVEL, DO0, DO1, VALID0, VALID1, OVF_ERR, UDF_ERR
  );

  modport slave (
    input  ENQ, DEQ, SLC0, DI,
    output FULL, EMPTY, LEVEL, DO0, DO1, VALID0, VALID1, OVF_ERR, UDF_ERR
  );

endinterface

// File: rtl/genbuf_fifo_mem.sv
// rtl/genbuf_fifo_mem.sv - DEPTH x WIDTH storage array for the GenBuf FIFO
//
// Purpose : plain register file, one synchronous write port and one
//           asynchronous read port. Contents are deliberately not reset.
// Ports   : i_clk   - clock, rising edge
//           i_we    - write enable
//           i_waddr - write index (tail pointer)
//           i_wdata - write data
//           i_raddr - read index (head pointer)
//           o_rdata - word at i_raddr, combinational

module genbuf_fifo_mem #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/genbuf_fifo.sv
// rtl/genbuf_fifo.sv - GenBuf data-path FIFO with dual receiver outputs
//
// Purpose : stores sender words on ENQ and, on DEQ, routes the head word to
//           receiver 0 or 1 (by SLC0) with a one-cycle valid strobe. Reports
//           registered FULL/EMPTY/LEVEL and sticky overflow/underflow flags.
// Ports   : clock - single clock, rising edge
//           reset - synchronous, active-high; wins over ENQ/DEQ
//           bus   - genbuf_fifo_if.slave (commands in, status/data out)

module genbuf_fifo
  import genbuf_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  genbuf_fifo_if.slave bus
);

  if (WIDTH < 1) begin : g_width_chk
    $error("genbuf_fifo: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_depth_chk
    $error("genbuf_fifo: DEPTH must be a power of two and >= 2");
  end

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             r_full;
  logic             r_empty;
  logic [WIDTH-1:0] r_do0;
  logic [WIDTH-1:0] r_do1;
  logic             r_valid0;
  logic             r_valid1;
  logic [ERR_W-1:0] r_err;

  logic             w_we;
  logic             w_re;
  logic             w_ovf;
  logic             w_udf;
  logic [AW:0]      w_cnt_nxt;
  logic [WIDTH-1:0] w_rdata;

  // A full FIFO still accepts a write when a pop frees the head slot in the
  // same edge. An empty FIFO never bypasses DI straight to the outputs.
  assign w_we  = bus.ENQ & (~r_full | bus.DEQ);
  assign w_re  = bus.DEQ & ~r_empty;
  assign w_ovf = bus.ENQ & r_full & ~bus.DEQ;
  assign w_udf = bus.DEQ & r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_we && !w_re) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (w_re && !w_we) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  genbuf_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (clock),
    .i_we    (w_we),
    .i_waddr (r_wp),
    .i_wdata (bus.DI),
    .i_raddr (r_rp),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_do0    <= '0;
      r_do1    <= '0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_err    <= '0;
    end else begin
      // Pointers wrap by natural AW-bit overflow since DEPTH is a power of two.
      if (w_we) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_re) begin
        r_rp <= r_rp + 1'b1;
      end

      // Status is derived from the next count so it is exact right after the edge.
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_FULL);
      r_empty <= (w_cnt_nxt == '0);

      r_valid0 <= w_re & (bus.SLC0 == RCV0);
      r_valid1 <= w_re & (bus.SLC0 == RCV1);
      if (w_re && bus.SLC0 == RCV0) begin
        r_do0 <= w_rdata;
      end
      if (w_re && bus.SLC0 == RCV1) begin
        r_do1 <= w_rdata;
      end

      if (w_ovf) begin
        r_err[ERR_OVF] <= 1'b1;
      end
      if (w_udf) begin
        r_err[ERR_UDF] <= 1'b1;
      end
    end
  end

  assign bus.FULL    = r_full;
  assign bus.EMPTY   = r_empty;
  assign bus.LEVEL   = r_cnt;
  assign bus.DO0     = r_do0;
  assign bus.DO1     = r_do1;
  assign bus.VALID0  = r_valid0;
  assign bus.VALID1  = r_valid1;
  assign bus.OVF_ERR = r_err[ERR_OVF];
  assign bus.UDF_ERR = r_err[ERR_UDF];

endmodule

// File: tb/tb_genbuf_fifo.sv
// tb/tb_genbuf_fifo.sv - scoreboard testbench for genbuf_fifo

module tb_genbuf_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic             slc;
    logic [WIDTH-1:0] data;
  } sb_t;

  logic clock;
  logic reset;

  int total = 0;
  int bad   = 0;
  int n_pops = 0;

  logic [WIDTH-1:0] mq [$];
  sb_t              sb [$];

  genbuf_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  genbuf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One clock of stimulus: the reference queue decides what should pop,
  // the expected delivery is pushed, then popped and compared after the edge.
  task automatic step(input logic enq, input logic deq, input logic slc,
                      input logic [WIDTH-1:0] di);
    sb_t e;
    bit  m_full;
    bit  m_empty;
    bus.ENQ  = enq;
    bus.DEQ  = deq;
    bus.SLC0 = slc;
    bus.DI   = di;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    if (deq && !m_empty) begin
      e.slc  = slc;
      e.data = mq.pop_front();
      sb.push_back(e);
    end
    if (enq && (!m_full || deq)) mq.push_back(di);
    @(posedge clock);
    #1;
    bus.ENQ = 1'b0;
    bus.DEQ = 1'b0;
    total++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_pops++;
      if (e.slc == 1'b0) begin
        if (bus.VALID0 !== 1'b1 || bus.VALID1 !== 1'b0 || bus.DO0 !== e.data) begin
          bad++;
          $display("FAIL sb_rcv0: valid0=%b valid1=%b do0=%h, required valid0=1 valid1=0 do0=%h",
                   bus.VALID0, bus.VALID1, bus.DO0, e.data);
        end
      end else begin
        if (bus.VALID1 !== 1'b1 || bus.VALID0 !== 1'b0 || bus.DO1 !== e.data) begin
          bad++;
          $display("FAIL sb_rcv1: valid0=%b valid1=%b do1=%h, required valid0=0 valid1=1 do1=%h",
                   bus.VALID0, bus.VALID1, bus.DO1, e.data);
        end
      end
    end else begin
      if (bus.VALID0 !== 1'b0 || bus.VALID1 !== 1'b0) begin
        bad++;
        $display("FAIL sb_spurious: valid0=%b valid1=%b, required both 0",
                 bus.VALID0, bus.VALID1);
      end
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.ENQ  = 1'b0;
    bus.DEQ  = 1'b0;
    bus.SLC0 = 1'b0;
    bus.DI   = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mq.delete();
    sb.delete();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.ENQ  = 1'b0;
    bus.DEQ  = 1'b0;
    bus.SLC0 = 1'b0;
    bus.DI   = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    total++;
    if (bus.EMPTY !== 1'b1 || bus.FULL !== 1'b0 || bus.LEVEL !== 3'd0) begin
      bad++;
      $display("FAIL reset_status: empty=%b full=%b level=%0d, required 1 0 0",
               bus.EMPTY, bus.FULL, bus.LEVEL);
    end
    total++;
    if (bus.DO0 !== 8'h00 || bus.DO1 !== 8'h00 || bus.VALID0 !== 1'b0 || bus.VALID1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: do0=%h do1=%h v0=%b v1=%b, required 00 00 0 0",
               bus.DO0, bus.DO1, bus.VALID0, bus.VALID1);
    end
    total++;
    if (bus.OVF_ERR !== 1'b0 || bus.UDF_ERR !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: ovf=%b udf=%b, required 0 0", bus.OVF_ERR, bus.UDF_ERR);
    end
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, d[i]);
      total++;
      if (bus.LEVEL !== 3'(i + 1) || bus.EMPTY !== 1'b0) begin
        bad++;
        $display("FAIL fill_level[%0d]: level=%0d empty=%b, required %0d 0",
                 i, bus.LEVEL, bus.EMPTY, i + 1);
      end
      total++;
      if (bus.FULL !== (i == 3)) begin
        bad++;
        $display("FAIL fill_full[%0d]: full=%b, required %b", i, bus.FULL, (i == 3));
      end
    end
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'(i % 2), 8'h00);
      total++;
      if ((i % 2) == 0 ? (bus.DO0 !== d[i] || bus.VALID0 !== 1'b1)
                       : (bus.DO1 !== d[i] || bus.VALID1 !== 1'b1)) begin
        bad++;
        $display("FAIL drain_data[%0d]: do0=%h do1=%h v0=%b v1=%b, required %h on rcv%0d",
                 i, bus.DO0, bus.DO1, bus.VALID0, bus.VALID1, d[i], i % 2);
      end
    end
    total++;
    if (bus.EMPTY !== 1'b1 || bus.LEVEL !== 3'd0) begin
      bad++;
      $display("FAIL drain_empty: empty=%b level=%0d, required 1 0", bus.EMPTY, bus.LEVEL);
    end
  endtask

  task automatic test_full_enq_deq();
    step(1'b1, 1'b0, 1'b0, 8'h11);
    step(1'b1, 1'b0, 1'b0, 8'h22);
    step(1'b1, 1'b0, 1'b0, 8'h33);
    step(1'b1, 1'b0, 1'b0, 8'h44);
    step(1'b1, 1'b1, 1'b0, 8'h55);
    total++;
    if (bus.DO0 !== 8'h11 || bus.VALID0 !== 1'b1 || bus.LEVEL !== 3'd4 ||
        bus.FULL !== 1'b1 || bus.OVF_ERR !== 1'b0) begin
      bad++;
      $display("FAIL full_enq_deq: do0=%h v0=%b level=%0d full=%b ovf=%b, required 11 1 4 1 0",
               bus.DO0, bus.VALID0, bus.LEVEL, bus.FULL, bus.OVF_ERR);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'h00);
    total++;
    if (bus.DO1 !== 8'h55 || bus.EMPTY !== 1'b1) begin
      bad++;
      $display("FAIL full_last_out: do1=%h empty=%b, required 55 1", bus.DO1, bus.EMPTY);
    end
  endtask

  task automatic test_ovf_udf();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'hA1 + 8'(i));
    step(1'b1, 1'b0, 1'b0, 8'h66);
    total++;
    if (bus.OVF_ERR !== 1'b1 || bus.LEVEL !== 3'd4 || bus.UDF_ERR !== 1'b0) begin
      bad++;
      $display("FAIL ovf_set: ovf=%b level=%0d udf=%b, required 1 4 0",
               bus.OVF_ERR, bus.LEVEL, bus.UDF_ERR);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    if (bus.DO0 !== 8'hA4 || bus.EMPTY !== 1'b1) begin
      bad++;
      $display("FAIL ovf_contents: do0=%h empty=%b, required a4 1", bus.DO0, bus.EMPTY);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    if (bus.UDF_ERR !== 1'b1 || bus.VALID0 !== 1'b0 || bus.VALID1 !== 1'b0 ||
        bus.DO0 !== 8'hA4) begin
      bad++;
      $display("FAIL udf_set: udf=%b v0=%b v1=%b do0=%h, required 1 0 0 a4",
               bus.UDF_ERR, bus.VALID0, bus.VALID1, bus.DO0);
    end
    step(1'b1, 1'b1, 1'b1, 8'h77);
    total++;
    if (bus.LEVEL !== 3'd1 || bus.EMPTY !== 1'b0 || bus.VALID1 !== 1'b0) begin
      bad++;
      $display("FAIL empty_enq_deq: level=%0d empty=%b v1=%b, required 1 0 0",
               bus.LEVEL, bus.EMPTY, bus.VALID1);
    end
    step(1'b0, 1'b1, 1'b1, 8'h00);
    total++;
    if (bus.DO1 !== 8'h77) begin
      bad++;
      $display("FAIL empty_enq_deq_out: do1=%h, required 77", bus.DO1);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    total++;
    if (bus.OVF_ERR !== 1'b1 || bus.UDF_ERR !== 1'b1) begin
      bad++;
      $display("FAIL flags_sticky: ovf=%b udf=%b, required 1 1", bus.OVF_ERR, bus.UDF_ERR);
    end
    do_reset();
    total++;
    if (bus.OVF_ERR !== 1'b0 || bus.UDF_ERR !== 1'b0) begin
      bad++;
      $display("FAIL flags_cleared: ovf=%b udf=%b, required 0 0", bus.OVF_ERR, bus.UDF_ERR);
    end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int pops0  = n_pops;
    int iter   = 0;
    logic enq;
    logic deq;
    while ((pushed < 10 || mq.size() != 0) && iter < 200) begin
      enq = (pushed < 10) && (mq.size() < 3) && ($urandom_range(0, 1) == 1);
      deq = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      step(enq, deq, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      if (enq) pushed++;
      iter++;
      total++;
      if (bus.LEVEL !== 3'(mq.size())) begin
        bad++;
        $display("FAIL wrap_level: level=%0d, required %0d", bus.LEVEL, mq.size());
      end
    end
    total++;
    if (n_pops - pops0 != 10) begin
      bad++;
      $display("FAIL wrap_count: delivered=%0d, required 10 (iterations %0d)",
               n_pops - pops0, iter);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'hC1);
    step(1'b1, 1'b0, 1'b0, 8'hC2);
    step(1'b1, 1'b0, 1'b0, 8'hC3);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    total++;
    if (bus.LEVEL !== 3'd2 || bus.VALID1 !== 1'b1 || bus.UDF_ERR !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: level=%0d v1=%b udf=%b, required 2 1 1",
               bus.LEVEL, bus.VALID1, bus.UDF_ERR);
    end
    reset   = 1'b1;
    bus.ENQ = 1'b1;
    bus.DI  = 8'h99;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    bus.ENQ = 1'b0;
    mq.delete();
    sb.delete();
    total++;
    if (bus.EMPTY !== 1'b1 || bus.LEVEL !== 3'd0 || bus.VALID0 !== 1'b0 ||
        bus.VALID1 !== 1'b0 || bus.OVF_ERR !== 1'b0 || bus.UDF_ERR !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: empty=%b level=%0d v0=%b v1=%b ovf=%b udf=%b, required 1 0 0 0 0 0",
               bus.EMPTY, bus.LEVEL, bus.VALID0, bus.VALID1, bus.OVF_ERR, bus.UDF_ERR);
    end
    step(1'b1, 1'b0, 1'b0, 8'hD1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    if (bus.DO0 !== 8'hD1 || bus.EMPTY !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: do0=%h empty=%b, required d1 1", bus.DO0, bus.EMPTY);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_enq_deq();
    test_ovf_udf();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
